// File: rtl/psg_sequencer_pkg.sv
// Shared types and constants for the PSG command-stream player.
// States, opcodes and the tone-volume registers cleared on stop.
package psg_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WRITE,
    WAIT,
    MUTE,
    DONE
  } psg_seq_state_t;

  typedef enum logic [1:0] {
    OP_WRITE,
    OP_WAIT,
    OP_LOOP,
    OP_END
  } psg_seq_op_t;

  localparam logic [3:0] PSG_REG_VOL_A = 4'd8;
  localparam logic [3:0] PSG_REG_VOL_B = 4'd9;
  localparam logic [3:0] PSG_REG_VOL_C = 4'd10;

  // Volume registers are contiguous, so the mute step is an offset.
  function automatic logic [3:0] mute_reg(
    input logic [1:0] step
  );
    return PSG_REG_VOL_A + {2'b00, step};
  endfunction

endpackage

// File: rtl/psg_sequencer_tick.sv
// Free-running frame tick divider.
// tick pulses for one cycle in the last count before wrap.
module tick_divider #(
  parameter int TICK_DIV = 450000
) (
  input  logic I_clk,
  input  logic I_reset_n,
  output logic tick
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/psg_sequencer.sv
// Command ROM player issuing YM2149 register writes.
// Paced by a frame tick; mutes tone channels A-C on stop.
module psg_sequencer
  import psg_sequencer_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int TICK_DIV       = 450000
) (
  input  logic                      I_clk,
  input  logic                      I_reset_n,
  input  logic                      I_play,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]               rom_data,
  output logic                      psg_wr,
  input  logic                      psg_ready,
  output logic [3:0]                psg_addr,
  output logic [7:0]                psg_data,
  output logic                      playing,
  output logic [7:0]                loop_count
);

  localparam int AW = ROM_ADDR_WIDTH;

  psg_seq_state_t state, state_n;
  psg_seq_op_t    op;

  logic [AW-1:0] pc, pc_n;
  logic [13:0]   wcnt, wcnt_n;
  logic [1:0]    step, step_n;
  logic          to_done, to_done_n;
  logic          wr_n, playing_n;
  logic [3:0]    addr_n;
  logic [7:0]    data_n, lcnt_n;
  logic          go_mute, mute_done;
  logic          tick, accept;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .tick      (tick)
  );

  assign op       = psg_seq_op_t'(rom_data[15:14]);
  assign accept   = psg_wr && psg_ready;
  assign rom_addr = pc;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    wcnt_n    = wcnt;
    step_n    = step;
    to_done_n = to_done;
    wr_n      = psg_wr;
    addr_n    = psg_addr;
    data_n    = psg_data;
    lcnt_n    = loop_count;
    go_mute   = 1'b0;
    mute_done = 1'b0;
    unique case (state)
      IDLE: begin
        pc_n = '0;
        if (I_play) begin
          state_n = FETCH;
          lcnt_n  = '0;
        end
      end
      FETCH: begin
        if (!I_play) go_mute = 1'b1;
        else state_n = DECODE;
      end
      DECODE: begin
        if (!I_play) begin
          go_mute = 1'b1;
        end else begin
          unique case (op)
            OP_WRITE: begin
              wr_n    = 1'b1;
              addr_n  = rom_data[11:8];
              data_n  = rom_data[7:0];
              state_n = WRITE;
            end
            OP_WAIT: begin
              wcnt_n  = (rom_data[13:0] == '0)
                      ? 14'd1 : rom_data[13:0];
              state_n = WAIT;
            end
            OP_LOOP: begin
              pc_n    = rom_data[AW-1:0];
              state_n = FETCH;
              if (loop_count != 8'hFF)
                lcnt_n = loop_count + 8'd1;
            end
            OP_END: begin
              go_mute   = 1'b1;
              mute_done = 1'b1;
            end
          endcase
        end
      end
      WRITE: begin
        if (accept) begin
          pc_n = pc + 1'b1;
          if (!I_play) begin
            go_mute = 1'b1;
          end else begin
            wr_n    = 1'b0;
            state_n = FETCH;
          end
        end
      end
      WAIT: begin
        if (!I_play) begin
          go_mute = 1'b1;
        end else if (tick) begin
          wcnt_n = wcnt - 14'd1;
          if (wcnt == 14'd1) begin
            pc_n    = pc + 1'b1;
            state_n = FETCH;
          end
        end
      end
      MUTE: begin
        if (accept) begin
          if (step == 2'd2) begin
            wr_n    = 1'b0;
            pc_n    = '0;
            state_n = to_done ? DONE : IDLE;
          end else begin
            step_n = step + 2'd1;
            addr_n = mute_reg(step + 2'd1);
          end
        end
      end
      DONE: begin
        if (!I_play) begin
          state_n = IDLE;
          pc_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
        wr_n    = 1'b0;
      end
    endcase
    // Entering MUTE raises the first write in the same edge.
    if (go_mute) begin
      state_n   = MUTE;
      step_n    = 2'd0;
      to_done_n = mute_done;
      wr_n      = 1'b1;
      addr_n    = PSG_REG_VOL_A;
      data_n    = 8'd0;
    end
    playing_n = (state_n == FETCH) ||
                (state_n == DECODE) ||
                (state_n == WRITE) ||
                (state_n == WAIT);
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state      <= IDLE;
      pc         <= '0;
      wcnt       <= '0;
      step       <= '0;
      to_done    <= 1'b0;
      psg_wr     <= 1'b0;
      psg_addr   <= '0;
      psg_data   <= '0;
      loop_count <= '0;
      playing    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      wcnt       <= wcnt_n;
      step       <= step_n;
      to_done    <= to_done_n;
      psg_wr     <= wr_n;
      psg_addr   <= addr_n;
      psg_data   <= data_n;
      loop_count <= lcnt_n;
      playing    <= playing_n;
    end
  end

endmodule

// File: tb/tb_psg_sequencer.sv
// Scoreboard bench for psg_sequencer with TICK_DIV=8.
// Expected PSG writes are queued by stimulus; a monitor checks accepts.
module tb_psg_sequencer;

  localparam int AW = 12;

  logic          I_clk = 1'b0;
  logic          I_reset_n = 1'b0;
  logic          I_play = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          psg_wr;
  logic          psg_ready;
  logic [3:0]    psg_addr;
  logic [7:0]    psg_data;
  logic          playing;
  logic [7:0]    loop_count;

  logic [15:0] rom [0:(1<<AW)-1];
  logic rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;
  logic rnd_bit  = 1'b1;
  int   cyc;
  int   n_chk = 0;
  int   n_pass = 0;

  typedef struct {
    int a;
    int d;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   acc_log[$];

  psg_sequencer #(
    .ROM_ADDR_WIDTH (AW),
    .TICK_DIV       (8)
  ) dut (
    .I_clk      (I_clk),
    .I_reset_n  (I_reset_n),
    .I_play     (I_play),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .psg_wr     (psg_wr),
    .psg_ready  (psg_ready),
    .psg_addr   (psg_addr),
    .psg_data   (psg_data),
    .playing    (playing),
    .loop_count (loop_count)
  );

  always #5 I_clk = ~I_clk;

  assign psg_ready = rdy_rand ? rnd_bit : rdy_val;

  always @(posedge I_clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 2) != 0);
  end

  always @(posedge I_clk) rom_data <= rom[rom_addr];

  // cycle k after reset release: divider count is k mod 8
  always @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic push_w(input int a, input int d,
                        input int p);
    exp_t e;
    e.a = a;
    e.d = d;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic push_mute();
    push_w(8, 0, 0);
    push_w(9, 0, 0);
    push_w(10, 0, 0);
  endtask

  task automatic wait_drain(input string nm,
                            input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || psg_wr) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_queue_drained"}, exp_q.size(), 0);
    chk({nm, "_wr_released"}, int'(psg_wr), 0);
  endtask

  task automatic wait_wr(input string nm, input int budget);
    int n = 0;
    while (!psg_wr && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_wr_seen"}, int'(psg_wr), 1);
  endtask

  // Monitor: handshake stability and accepted-write scoreboard
  logic       prev_wr = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [3:0] prev_a = '0;
  logic [7:0] prev_d = '0;

  always @(negedge I_clk) begin : mon
    exp_t e;
    if (!I_reset_n) begin
      prev_wr = 1'b0;
    end else begin
      if (prev_wr && !prev_rdy) begin
        chk("hold_wr", int'(psg_wr), 1);
        chk("hold_addr", int'(psg_addr), int'(prev_a));
        chk("hold_data", int'(psg_data), int'(prev_d));
      end
      if (psg_wr && psg_ready) begin
        acc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got reg %0d data %0d expected none",
                   psg_addr, psg_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(psg_addr), e.a);
          chk("wr_data", int'(psg_data), e.d);
          chk("wr_playing", int'(playing), e.p);
        end
      end
      prev_wr  = psg_wr;
      prev_rdy = psg_ready;
      prev_a   = psg_addr;
      prev_d   = psg_data;
    end
  end

  initial begin
    int p, d, w0, t, cnt, need, len, n;
    int waits[4];
    waits = '{3, 0, 2, 1};
    for (int i = 0; i < (1 << AW); i++) rom[i] = 16'hC000;
    repeat (3) step();
    chk("rst_wr", int'(psg_wr), 0);
    chk("rst_addr", int'(psg_addr), 0);
    chk("rst_data", int'(psg_data), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_loops", int'(loop_count), 0);
    I_reset_n = 1'b1;
    step();
    step();

    // 1: two writes, END, mute, DONE holds
    rom[0] = 16'h0701;
    rom[1] = 16'h080F;
    rom[2] = 16'hC000;
    push_w(7, 1, 1);
    push_w(8, 15, 1);
    push_mute();
    acc_log.delete();
    p = cyc;
    I_play = 1'b1;
    wait_drain("s1", 100);
    chk("s1_acc_count", acc_log.size(), 5);
    if (acc_log.size() == 5) begin
      chk("s1_t_wr0", acc_log[0], p + 3);
      chk("s1_t_wr1", acc_log[1], p + 6);
      chk("s1_t_mute0", acc_log[2], p + 9);
      chk("s1_t_mute1", acc_log[3], p + 10);
      chk("s1_t_mute2", acc_log[4], p + 11);
    end
    repeat (10) step();
    chk("s1_done_playing", int'(playing), 0);
    I_play = 1'b0;
    step();
    step();
    chk("s1_idle_rom_addr", int'(rom_addr), 0);

    // 2: stalled handshake, reserved bits ignored
    rom[0] = 16'h3312;
    rom[1] = 16'hC000;
    rdy_val = 1'b0;
    push_w(3, 8'h12, 1);
    push_mute();
    I_play = 1'b1;
    wait_wr("s2", 20);
    w0 = cyc;
    acc_log.delete();
    repeat (5) step();
    rdy_val = 1'b1;
    wait_drain("s2", 100);
    if (acc_log.size() == 4) begin
      chk("s2_accept_delay", acc_log[0] - w0, 5);
      chk("s2_mute_consec", acc_log[3] - acc_log[1], 2);
    end else begin
      chk("s2_acc_count", acc_log.size(), 4);
    end
    I_play = 1'b0;
    step();
    step();

    // 3: WAIT timing against the tick grid
    foreach (waits[j]) begin
      rom[0] = 16'h4000 | 16'(waits[j]);
      rom[1] = 16'h0123;
      rom[2] = 16'hC000;
      repeat ($urandom_range(0, 7)) step();
      push_w(1, 8'h23, 1);
      push_mute();
      acc_log.delete();
      p = cyc;
      I_play = 1'b1;
      need = (waits[j] == 0) ? 1 : waits[j];
      cnt = 0;
      t = p + 3;
      while (1) begin
        if (t % 8 == 7) begin
          cnt++;
          if (cnt == need) break;
        end
        t++;
      end
      wait_drain("s3", 200);
      if (acc_log.size() > 0)
        chk($sformatf("s3_wait%0d_timing", waits[j]),
            acc_log[0], t + 3);
      I_play = 1'b0;
      step();
      step();
    end

    // 4: loop counting and saturation
    rom[0] = 16'h0A55;
    rom[1] = 16'h8000;
    for (int i = 0; i < 4; i++) push_w(10, 8'h55, 1);
    push_mute();
    I_play = 1'b1;
    n = 0;
    while (loop_count != 8'd4 && n < 100) begin
      step();
      n++;
    end
    I_play = 1'b0;
    wait_drain("s4", 100);
    chk("s4_loop_count", int'(loop_count), 4);
    step();
    rom[0] = 16'h8000;
    push_mute();
    I_play = 1'b1;
    repeat (620) step();
    chk("s4_sat_playing", int'(playing), 1);
    chk("s4_sat_loops", int'(loop_count), 255);
    I_play = 1'b0;
    wait_drain("s4sat", 50);
    chk("s4_sat_hold", int'(loop_count), 255);
    step();
    rom[0] = 16'hC000;
    push_mute();
    I_play = 1'b1;
    step();
    step();
    chk("s4_loops_cleared", int'(loop_count), 0);
    wait_drain("s4end", 50);
    I_play = 1'b0;
    step();
    step();

    // 5a: stop during WAIT, returns to IDLE
    rom[0] = 16'h4005;
    rom[1] = 16'h0123;
    rom[2] = 16'hC000;
    I_play = 1'b1;
    repeat (6) step();
    push_mute();
    acc_log.delete();
    d = cyc;
    I_play = 1'b0;
    wait_drain("s5a", 50);
    if (acc_log.size() > 0)
      chk("s5a_mute_latency",
          int'(acc_log[0] - d >= 1 && acc_log[0] - d <= 2), 1);
    chk("s5a_stopped", int'(playing), 0);
    I_play = 1'b1;
    step();
    step();
    step();
    chk("s5a_restart_from_idle", int'(playing), 1);
    push_mute();
    I_play = 1'b0;
    wait_drain("s5a2", 50);

    // 5b: stop while write stalled
    rom[0] = 16'h0577;
    rom[1] = 16'hC000;
    rdy_val = 1'b0;
    push_w(5, 8'h77, 1);
    push_mute();
    I_play = 1'b1;
    wait_wr("s5b", 20);
    I_play = 1'b0;
    repeat (3) step();
    rdy_val = 1'b1;
    wait_drain("s5b", 50);
    step();
    chk("s5b_playing", int'(playing), 0);
    chk("s5b_rom_addr", int'(rom_addr), 0);

    // 6: async reset mid-handshake
    rom[0] = 16'h0699;
    rom[1] = 16'hC000;
    rdy_val = 1'b0;
    I_play = 1'b1;
    wait_wr("s6", 20);
    step();
    #2;
    I_reset_n = 1'b0;
    #1;
    chk("s6_wr", int'(psg_wr), 0);
    chk("s6_addr", int'(psg_addr), 0);
    chk("s6_data", int'(psg_data), 0);
    chk("s6_rom_addr", int'(rom_addr), 0);
    chk("s6_playing", int'(playing), 0);
    chk("s6_loops", int'(loop_count), 0);
    I_play = 1'b0;
    step();
    step();
    I_reset_n = 1'b1;
    step();
    step();
    chk("s6_post_rom_addr", int'(rom_addr), 0);
    chk("s6_post_playing", int'(playing), 0);
    rdy_val = 1'b1;
    push_w(6, 8'h99, 1);
    push_mute();
    I_play = 1'b1;
    wait_drain("s6run", 100);
    I_play = 1'b0;
    step();
    step();

    // Random programs with random backpressure
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(4, 10);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          rom[i] = 16'h4000 | 16'($urandom_range(0, 2));
        end else begin
          logic [3:0] ra;
          logic [7:0] rd;
          logic [1:0] rh;
          ra = 4'($urandom);
          rd = 8'($urandom);
          rh = 2'($urandom);
          rom[i] = {2'b00, rh, ra, rd};
          push_w(int'(ra), int'(rd), 1);
        end
      end
      rom[len] = 16'hC000;
      push_mute();
      rdy_rand = 1'b1;
      I_play = 1'b1;
      wait_drain("rnd", 1500);
      rdy_rand = 1'b0;
      repeat (3) step();
      chk("rnd_done_playing", int'(playing), 0);
      I_play = 1'b0;
      step();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
